// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word access to a 32-bit word-addressed data memory.
// Define LSU_SUBWORD_STORE_EN to enable byte/half stores via read-modify-write.
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    LD_CAP,
    MERGE,
    WR,
    RESP
  } state_e;

  state_e state_q, state_d;

  logic        write_q;
  logic        signed_q;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic [31:0] addr_q;
  logic [31:0] wdat_q;
  logic [31:0] rdata_q;
  logic        mis_q;

  logic        accept;
  logic        align_fault;
  logic        st_fault;
  logic        fault;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_val;
  logic [31:0] merged;

  assign accept = req_valid & req_ready;

  always_comb begin
    align_fault = 1'b0;
    unique case (req_size)
      2'b00:   align_fault = 1'b0;
      2'b01:   align_fault = req_addr[0];
      2'b10:   align_fault = |req_addr[1:0];
      default: align_fault = 1'b1;
    endcase
  end

`ifdef LSU_SUBWORD_STORE_EN
  assign st_fault = 1'b0;
`else
  // Without read-modify-write support, sub-word stores cannot be performed.
  assign st_fault = req_write & (req_size != 2'b10);
`endif

  assign fault = align_fault | st_fault;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (fault) begin
            state_d = RESP;
          end else if (!req_write) begin
            state_d = RD;
          end else if (req_size == 2'b10) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD:      state_d = write_q ? MERGE : LD_CAP;
      LD_CAP:  state_d = RESP;
      MERGE:   state_d = WR;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ld_b = mem_read_data[7:0];
    unique case (lane_q)
      2'd1:    ld_b = mem_read_data[15:8];
      2'd2:    ld_b = mem_read_data[23:16];
      2'd3:    ld_b = mem_read_data[31:24];
      default: ld_b = mem_read_data[7:0];
    endcase
    ld_h = lane_q[1] ? mem_read_data[31:16]
                     : mem_read_data[15:0];
    unique case (size_q)
      2'b00:   ld_val = {{24{signed_q & ld_b[7]}}, ld_b};
      2'b01:   ld_val = {{16{signed_q & ld_h[15]}}, ld_h};
      default: ld_val = mem_read_data;
    endcase
  end

  always_comb begin
    merged = mem_read_data;
    if (size_q == 2'b00) begin
      unique case (lane_q)
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        2'd3:    merged[31:24] = wdata_q[7:0];
        default: merged[7:0]   = wdata_q[7:0];
      endcase
    end else if (lane_q[1]) begin
      merged[31:16] = wdata_q;
    end else begin
      merged[15:0] = wdata_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= 2'b00;
      lane_q   <= 2'b00;
      wdata_q  <= '0;
      addr_q   <= '0;
      wdat_q   <= '0;
      rdata_q  <= '0;
      mis_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q  <= req_write;
        signed_q <= req_signed;
        size_q   <= req_size;
        lane_q   <= req_addr[1:0];
        wdata_q  <= req_wdata[15:0];
        addr_q   <= {req_addr[31:2], 2'b00};
        if (req_write) begin
          wdat_q <= req_wdata;
        end
      end
      if (state_q == MERGE) begin
        wdat_q <= merged;
      end
      // Response fields only change on the edge entering RESP.
      if (accept && fault) begin
        rdata_q <= '0;
        mis_q   <= 1'b1;
      end else if (state_q == LD_CAP) begin
        rdata_q <= ld_val;
        mis_q   <= 1'b0;
      end else if (state_q == WR) begin
        rdata_q <= '0;
        mis_q   <= 1'b0;
      end
    end
  end

  assign req_ready       = (state_q == IDLE);
  assign resp_valid      = (state_q == RESP);
  assign MemRead         = (state_q == RD);
  assign MemWrite        = (state_q == WR);
  assign mem_address     = addr_q;
  assign mem_write_data  = wdat_q;
  assign resp_rdata      = rdata_q;
  assign resp_misaligned = mis_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: random requests against a word-array memory
// and a behavioural model of load extraction, store merging and latency.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] mem_rd = '0;

  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic        poke = 1'b0;
  logic [5:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;

  int total = 0;
  int bad = 0;

  load_store_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_size        (req_size),
    .req_signed      (req_signed),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned),
    .mem_address     (mem_address),
    .mem_write_data  (mem_write_data),
    .MemRead         (MemRead),
    .MemWrite        (MemWrite),
    .mem_read_data   (mem_rd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (MemRead) mem_rd <= mem[mem_address[7:2]];
    if (MemWrite) mem[mem_address[7:2]] <= mem_write_data;
    if (poke) mem[poke_idx] <= poke_val;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic put_word(input int idx, input logic [31:0] v);
    @(negedge clk);
    poke = 1'b1;
    poke_idx = 6'(idx);
    poke_val = v;
    ref_mem[idx] = v;
    @(posedge clk);
    #1 poke = 1'b0;
  endtask

  function automatic logic [31:0] ld_model(input logic [31:0] w,
                                           input logic [1:0] sz,
                                           input logic sg,
                                           input logic [31:0] a);
    logic [31:0] v;
    v = w >> (8 * a[1:0]);
    if (sz == 2'd0) begin
      v = v & 32'hFF;
      if (sg && v[7]) v = v | 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      v = v & 32'hFFFF;
      if (sg && v[15]) v = v | 32'hFFFF0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] st_model(input logic [31:0] w,
                                           input logic [1:0] sz,
                                           input logic [31:0] a,
                                           input logic [31:0] wd);
    logic [31:0] m;
    m = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFFFFFF;
    m = m << (8 * a[1:0]);
    return (w & ~m) | ((wd << (8 * a[1:0])) & m);
  endfunction

  task automatic run_req(input logic wr,
                         input logic [1:0] sz,
                         input logic sg,
                         input logic [31:0] a,
                         input logic [31:0] wd,
                         output logic [31:0] r,
                         output logic mis);
    int idx, e_lat, e_rd, e_wr, lat, nrd, nwr, wcyc;
    logic e_f;
    logic [31:0] e_data, e_new, wdat;
    idx = int'(a[7:2]);
    e_f = (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
          (sz == 2'd2 && a[1:0] != 2'b00);
`ifndef LSU_SUBWORD_STORE_EN
    if (wr && sz != 2'd2) e_f = 1'b1;
`endif
    e_data = '0;
    e_new = ref_mem[idx];
    if (e_f) begin
      e_lat = 1; e_rd = 0; e_wr = 0;
    end else if (!wr) begin
      e_lat = 3; e_rd = 1; e_wr = 0;
      e_data = ld_model(ref_mem[idx], sz, sg, a);
    end else if (sz == 2'd2) begin
      e_lat = 2; e_rd = 0; e_wr = 1;
      e_new = wd;
    end else begin
      e_lat = 4; e_rd = 1; e_wr = 1;
      e_new = st_model(ref_mem[idx], sz, a, wd);
    end

    @(negedge clk);
    chk("ready_idle", 32'(req_ready), 1);
    req_valid = 1'b1;
    req_write = wr;
    req_size = sz;
    req_signed = sg;
    req_addr = a;
    req_wdata = wd;
    @(posedge clk);
    #1;
    // Busy-time requests with junk fields must be ignored.
    req_write = 1'($urandom);
    req_size = 2'($urandom);
    req_addr = $urandom;
    req_wdata = $urandom;
    lat = 0; nrd = 0; nwr = 0; wcyc = 0;
    wdat = '0; r = '0; mis = 1'b0;
    for (int n = 1; n <= 8 && lat == 0; n++) begin
      @(negedge clk);
      chk("strobe_excl", 32'(MemRead & MemWrite), 0);
      if (MemRead) begin
        nrd++;
        chk("rd_addr", mem_address, {a[31:2], 2'b00});
      end
      if (MemWrite) begin
        nwr++;
        wcyc = n;
        wdat = mem_write_data;
        chk("wr_addr", mem_address, {a[31:2], 2'b00});
      end
      if (resp_valid) begin
        lat = n;
        r = resp_rdata;
        mis = resp_misaligned;
        chk("ready_resp", 32'(req_ready), 0);
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    chk("latency", lat, e_lat);
    chk("rdata", r, e_data);
    chk("misaligned", 32'(mis), 32'(e_f));
    chk("n_read", nrd, e_rd);
    chk("n_write", nwr, e_wr);
    if (e_wr == 1) begin
      chk("wr_cycle", wcyc, e_lat - 1);
      chk("wr_data", wdat, e_new);
    end
    ref_mem[idx] = e_new;
    @(negedge clk);
    chk("resp_pulse", 32'(resp_valid), 0);
    chk("rdata_hold", resp_rdata, e_data);
    chk("mis_hold", 32'(resp_misaligned), 32'(e_f));
  endtask

  task automatic reset_mid(input logic wr,
                           input logic [1:0] sz,
                           input logic [31:0] a,
                           input logic [31:0] wd,
                           input int at_n);
    int ns;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_size = sz;
    req_signed = 1'b0;
    req_addr = a;
    req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int n = 1; n <= at_n; n++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_ready", 32'(req_ready), 1);
    chk("mid_rd", 32'(MemRead), 0);
    chk("mid_wr", 32'(MemWrite), 0);
    chk("mid_resp", 32'(resp_valid), 0);
    chk("mid_addr", mem_address, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ns = 0;
    repeat (6) begin
      @(negedge clk);
      ns += int'(MemRead) + int'(MemWrite) + int'(resp_valid);
    end
    chk("mid_quiet", ns, 0);
    chk("mid_mem", mem[a[7:2]], ref_mem[a[7:2]]);
  endtask

  initial begin
    logic [31:0] r;
    logic m;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size = 2'b00;
    req_signed = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    #1;
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_memrd", 32'(MemRead), 0);
    chk("rst_memwr", 32'(MemWrite), 0);
    chk("rst_resp", 32'(resp_valid), 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_mis", 32'(resp_misaligned), 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_wdata", mem_write_data, 0);
    for (int i = 0; i < 64; i++) put_word(i, $urandom);
    @(negedge clk);
    rst_n = 1'b1;

    put_word(4, 32'h11223344);
    run_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, r, m);
    chk("ld_byte_13", r, 32'h00000011);
    put_word(4, 32'h80FF7F01);
    run_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, r, m);
    chk("ld_half_s", r, 32'hFFFF80FF);
    run_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, r, m);
    chk("ld_half_u", r, 32'h000080FF);
    run_req(1'b0, 2'd2, 1'b0, 32'h06, 32'h0, r, m);
    chk("ld_word_06", 32'(m), 1);
`ifdef LSU_SUBWORD_STORE_EN
    put_word(4, 32'h11223344);
    run_req(1'b1, 2'd0, 1'b0, 32'h11, 32'hAB, r, m);
    chk("st_byte_11", mem[4], 32'h1122AB44);
    put_word(4, 32'h11223344);
    reset_mid(1'b1, 2'd0, 32'h11, 32'hAB, 2);
`else
    put_word(8, 32'hCAFEF00D);
    run_req(1'b1, 2'd1, 1'b0, 32'h20, 32'h5566, r, m);
    chk("st_half_20", 32'(m), 1);
    chk("st_half_mem", mem[8], 32'hCAFEF00D);
    reset_mid(1'b0, 2'd2, 32'h40, 32'h0, 1);
`endif

    for (int k = 0; k < 300; k++) begin
      run_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)),
              $urandom, r, m);
    end

    for (int i = 0; i < 64; i++) chk("mem_final", mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters SHALL be none; all widths fixed at 32-bit data/address.
REQ-002 clk  input  1  single clock, rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  CPU access request.
REQ-005 req_ready  output  1  unit idle and accepting; high only in IDLE.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 half, 10 word, 11 invalid.
REQ-008 req_signed  input  1  sign-extend sub-word loads.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-justified.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  extended load result; 0 for stores and faults.
REQ-013 resp_misaligned  output  1  fault flag, valid with resp_valid.
REQ-014 mem_address  output  32  word address to data memory; bits [1:0] always 00.
REQ-015 mem_write_data  output  32  word to data memory.
REQ-016 MemRead / MemWrite  output  1 each  data-memory strobes.
REQ-017 mem_read_data  input  32  data memory output, valid the cycle after MemRead.

Function
REQ-018 Accept SHALL occur on a clock edge with req_valid & req_ready; all request fields are latched at accept.
REQ-019 States SHALL be IDLE, RD, LD_CAP, MERGE, WR, RESP.
REQ-020 A fault SHALL be raised for half with addr[0]=1, word with addr[1:0]!=0, or size 11; IDLE->RESP, no strobe, resp_misaligned=1.
REQ-021 Load path SHALL be IDLE->RD (MemRead=1)->LD_CAP (extract and register)->RESP, so resp_valid rises 3 cycles after accept.
REQ-022 Byte lanes SHALL be little-endian: addr[1:0]=0 selects bits [7:0]; a half at addr[1]=1 selects bits [31:16].
REQ-023 Sub-word loads SHALL be zero-extended when req_signed=0, else sign-extended from the lane MSB.
REQ-024 Word store path SHALL be IDLE->WR (MemWrite=1, mem_write_data=req_wdata)->RESP, so resp_valid rises 2 cycles after accept.
REQ-025 Sub-word store path SHALL be IDLE->RD (MemRead)->MERGE (replace the addressed lane with req_wdata low bits, others kept)->WR->RESP, so resp_valid rises 4 cycles after accept.
REQ-026 Each strobe SHALL be high for exactly one cycle, never both together, and both low outside RD/WR.
REQ-027 In RESP, resp_valid SHALL be 1 for one cycle with no back-pressure, then return to IDLE; req_ready=0 in RESP.
REQ-028 resp_rdata and resp_misaligned SHALL hold their values until the next response.
REQ-029 While req_ready=0, req_valid SHALL be ignored and no queueing occurs.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, MemRead=0, MemWrite=0, resp_valid=0, resp_rdata=0, resp_misaligned=0, mem_address=0, mem_write_data=0, req_ready=1.
REQ-031 Reset mid-operation SHALL abort the access with no response and no further strobe; an uncompleted RMW leaves memory unmodified.

Configuration
REQ-032 Macro LSU_SUBWORD_STORE_EN defined SHALL enable the REQ-025 read-modify-write store path.
REQ-033 Without LSU_SUBWORD_STORE_EN, byte/half stores SHALL be faulted per REQ-020 with no memory access; loads are unaffected.

Verification
REQ-034 Mem[0x10]=0x11223344, load byte signed at 0x13 -> resp_rdata 0x00000011 at accept+3.
REQ-035 Mem[0x10]=0x80FF7F01, load half signed at 0x12 -> 0xFFFF80FF; unsigned -> 0x000080FF.
REQ-036 Store byte 0xAB at 0x11 over 0x11223344 (EN defined) -> single MemWrite of 0x1122AB44 at accept+3, resp_valid at accept+4.
REQ-037 Word load at 0x06 -> resp_misaligned=1 at accept+1, no MemRead/MemWrite.
REQ-038 rst_n low during the MERGE state of a byte store -> no MemWrite, req_ready=1 immediately, memory unchanged.
REQ-039 Without the macro, store half 0x5566 at 0x20 -> resp_misaligned=1, no MemWrite.
